// File: rtl/bitty_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// bitty_fetch_sequencer
//
// Purpose:
//   Fetches 16-bit instructions from an instruction memory one at a time,
//   presents each one to bitty_processor and waits for it to finish before
//   advancing the program counter. A designated halt word stops sequencing
//   until start is pulsed again, which restarts the program from address 0.
//
// Parameters:
//   ADDR_W     - program counter / memory address width
//   HALT_INSTR - instruction word that stops sequencing (not issued)
//   TIMEOUT    - maximum WAIT_MEM cycles before the fetch is re-issued
//                (only meaningful when FETCH_TIMEOUT_EN is defined)
//
// Build option:
//   FETCH_TIMEOUT_EN - when defined, a wait counter runs in WAIT_MEM and a
//                      fetch that gets no mem_valid within TIMEOUT cycles
//                      is retried at the same pc. When undefined, WAIT_MEM
//                      waits forever and no counter is built.
//
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   asynchronous active-low reset
//   start        in   begin execution (IDLE) or restart from 0 (HALTED)
//   mem_req      out  one-cycle instruction-memory read request
//   mem_addr     out  read address, always equal to pc
//   mem_rdata    in   instruction word from memory
//   mem_valid    in   mem_rdata valid this cycle
//   instruction  out  instruction presented to bitty_processor
//   instr_valid  out  one-cycle pulse marking a new instruction
//   done         in   completion pulse from bitty_processor
//   pc           out  current program counter
//   halted       out  high while in HALTED
//   retired      out  count of completed instructions (wraps)
// ---------------------------------------------------------------------------
module bitty_fetch_sequencer #(
    parameter int          ADDR_W     = 8,
    parameter logic [15:0] HALT_INSTR = 16'hFFFF,
    parameter int          TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_valid,
    output logic [15:0]       instruction,
    output logic              instr_valid,
    input  logic              done,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [15:0]       retired
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_MEM,
        ISSUE,
        EXEC,
        HALTED
    } state_t;

    state_t state;
    state_t state_next;

    // A returned word is either a real instruction (goes to ISSUE) or the
    // halt word (goes straight to HALTED and is never latched or issued).
    logic rdata_is_halt;
    logic capture_instr;
    logic advance_pc;
    logic restart_pc;

    assign rdata_is_halt = (mem_rdata == HALT_INSTR);
    assign capture_instr = (state == WAIT_MEM) && mem_valid && !rdata_is_halt;
    assign advance_pc    = (state == EXEC) && done;
    assign restart_pc    = (state == HALTED) && start;

`ifdef FETCH_TIMEOUT_EN
    // Counter sized to hold TIMEOUT; it counts WAIT_MEM cycles already spent.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             wait_expired;

    // The TIMEOUT-th consecutive WAIT_MEM cycle without mem_valid gives up
    // and sends the sequencer back to FETCH for the same pc.
    assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT - 1));

    // Cleared whenever we are outside WAIT_MEM so every fetch attempt gets
    // a fresh budget, including retries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (state == WAIT_MEM) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. start only matters in IDLE and HALTED, done only in
    // EXEC, mem_valid only in WAIT_MEM; everything else is ignored.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                state_next = WAIT_MEM;
            end
            WAIT_MEM: begin
                if (mem_valid) begin
                    state_next = rdata_is_halt ? HALTED : ISSUE;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (wait_expired) begin
                    state_next = FETCH;
                end
`endif
            end
            ISSUE: begin
                state_next = EXEC;
            end
            EXEC: begin
                if (done) begin
                    state_next = FETCH;
                end
            end
            HALTED: begin
                if (start) begin
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are pure decodes of the state, so reset clears them at once
    // without waiting for a clock edge.
    always_comb begin
        mem_req     = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        unique case (state)
            FETCH:   mem_req     = 1'b1;
            ISSUE:   instr_valid = 1'b1;
            HALTED:  halted      = 1'b1;
            default: begin
            end
        endcase
    end

    assign mem_addr = pc;

    // Program counter: advances (with natural wrap) when an instruction
    // completes, and returns to 0 on a restart out of HALTED. A start from
    // IDLE keeps the current pc, which is 0 after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= '0;
        end else if (advance_pc) begin
            pc <= pc + ADDR_W'(1);
        end else if (restart_pc) begin
            pc <= '0;
        end
    end

    // Instruction latch: holds the last real instruction until the next
    // capture; the halt word leaves it untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instruction <= 16'h0000;
        end else if (capture_instr) begin
            instruction <= mem_rdata;
        end
    end

    // Retired count survives a restart from HALTED; only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired <= 16'h0000;
        end else if (advance_pc) begin
            retired <= retired + 16'd1;
        end
    end

endmodule

// File: tb/tb_bitty_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bitty_fetch_sequencer
//
// Directed bench for bitty_fetch_sequencer with default parameters
// (ADDR_W=8, HALT_INSTR=16'hFFFF, TIMEOUT=16). Inputs are driven 1 time
// unit after each rising edge and outputs are checked at the same point.
// ---------------------------------------------------------------------------
module tb_bitty_fetch_sequencer;

    localparam int ADDR_W = 8;

    logic              clk;
    logic              reset;
    logic              start;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_rdata;
    logic              mem_valid;
    logic [15:0]       instruction;
    logic              instr_valid;
    logic              done;
    logic [ADDR_W-1:0] pc;
    logic              halted;
    logic [15:0]       retired;

    int check_count;
    int pass_count;

    bitty_fetch_sequencer #(
        .ADDR_W    (ADDR_W),
        .HALT_INSTR(16'hFFFF),
        .TIMEOUT   (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_valid  (mem_valid),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .done       (done),
        .pc         (pc),
        .halted     (halted),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic mv,
                                 input logic [15:0] rd, input logic d);
        start     = s;
        mem_valid = mv;
        mem_rdata = rd;
        done      = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits up to a bounded number of cycles for mem_req.
    task automatic wait_for_req(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Runs one instruction starting from FETCH: memory answers on the first
    // WAIT_MEM cycle, done is given on the first EXEC cycle.
    task automatic do_instr(input logic [15:0] word);
        tick();
        applyStimulus(1'b0, 1'b1, word, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    endtask

    logic [15:0] prog [0:2];
    int          pulses;
    int          reqs;
    int          second_req_at;
    bit          seen;
    bit          bad_addr;

    initial begin
        check_count = 0;
        pass_count  = 0;
        prog[0] = 16'h0A01;
        prog[1] = 16'h0B02;
        prog[2] = 16'hFFFF;
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        reset = 1'b1;
        #3 reset = 1'b0;
        #2;
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_instr_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        checkOutput("rst_pc", 32'(pc), 32'd0);
        checkOutput("rst_instruction", 32'(instruction), 32'h0000);
        checkOutput("rst_retired", 32'(retired), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        checkOutput("idle_no_req", 32'(mem_req), 32'd0);

        // ---- single fetch, memory two cycles late ----
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("t1_req", 32'(mem_req), 32'd1);
        checkOutput("t1_addr", 32'(mem_addr), 32'd0);
        tick();
        checkOutput("t1_req_one_cycle", 32'(mem_req), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b1, 16'h1234, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("t1_instr_valid", 32'(instr_valid), 32'd1);
        checkOutput("t1_instruction", 32'(instruction), 32'h1234);
        // start held high during EXEC must be ignored
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        tick();
        checkOutput("t1_pulse_one_cycle", 32'(instr_valid), 32'd0);
        tick();
        checkOutput("t1_start_ignored", 32'(mem_req), 32'd0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("t1_pc", 32'(pc), 32'd1);
        checkOutput("t1_retired", 32'(retired), 32'd1);
        checkOutput("t1_req2", 32'(mem_req), 32'd1);
        checkOutput("t1_addr2", 32'(mem_addr), 32'd1);

        // ---- three-word program ending in the halt word ----
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            wait_for_req(seen);
            if (!seen) begin
                checkOutput("t2_req_timeout", 32'd0, 32'd1);
                break;
            end
            tick();
            tick();
            applyStimulus(1'b0, 1'b1, prog[mem_addr], 1'b0);
            tick();
            applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
            if (halted) break;
            if (instr_valid) pulses++;
            tick();
            tick();
            tick();
            applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
            tick();
            applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        end
        checkOutput("t2_pulses", 32'(pulses), 32'd2);
        checkOutput("t2_halted", 32'(halted), 32'd1);
        checkOutput("t2_pc", 32'(pc), 32'd2);
        checkOutput("t2_retired", 32'(retired), 32'd2);
        checkOutput("t2_instr_kept", 32'(instruction), 32'h0B02);
        reqs = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_req) reqs++;
        end
        checkOutput("t2_no_more_req", 32'(reqs), 32'd0);
        checkOutput("t2_still_halted", 32'(halted), 32'd1);

        // ---- restart from HALTED ----
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("t3_pc", 32'(pc), 32'd0);
        checkOutput("t3_req", 32'(mem_req), 32'd1);
        checkOutput("t3_addr", 32'(mem_addr), 32'd0);
        checkOutput("t3_halted_drop", 32'(halted), 32'd0);
        checkOutput("t3_retired", 32'(retired), 32'd2);

        // ---- pc wrap: 255 instructions take pc to 8'hFF, one more wraps ----
        for (int i = 0; i < 255; i++) begin
            do_instr(16'h0001);
        end
        checkOutput("t4_pc_ff", 32'(pc), 32'hFF);
        checkOutput("t4_retired", 32'(retired), 32'd257);
        do_instr(16'h0002);
        checkOutput("t4_pc_wrap", 32'(pc), 32'd0);
        checkOutput("t4_req", 32'(mem_req), 32'd1);
        checkOutput("t4_addr", 32'(mem_addr), 32'd0);

        // ---- reset during EXEC ----
        tick();
        applyStimulus(1'b0, 1'b1, 16'h1234, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        tick();
        checkOutput("t5_instr_before", 32'(instruction), 32'h1234);
        #2 reset = 1'b0;
        #1;
        checkOutput("t5_instruction", 32'(instruction), 32'h0000);
        checkOutput("t5_pc", 32'(pc), 32'd0);
        checkOutput("t5_retired", 32'(retired), 32'd0);
        checkOutput("t5_req", 32'(mem_req), 32'd0);
        checkOutput("t5_instr_valid", 32'(instr_valid), 32'd0);
        checkOutput("t5_halted", 32'(halted), 32'd0);
        tick();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b1, 16'h5555, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        tick();
        checkOutput("t5_late_pc", 32'(pc), 32'd0);
        checkOutput("t5_late_retired", 32'(retired), 32'd0);
        checkOutput("t5_late_instr", 32'(instruction), 32'h0000);
        checkOutput("t5_late_req", 32'(mem_req), 32'd0);

        // ---- silent memory for 20 cycles ----
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        reqs          = mem_req ? 1 : 0;
        second_req_at = -1;
        bad_addr      = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (mem_req) begin
                reqs++;
                if (mem_addr != 8'd0) bad_addr = 1'b1;
                if (second_req_at < 0) second_req_at = c;
            end
        end
`ifdef FETCH_TIMEOUT_EN
        checkOutput("t6_req_count", 32'(reqs), 32'd2);
        checkOutput("t6_retry_cycle", 32'(second_req_at), 32'd17);
        checkOutput("t6_retry_addr", 32'(bad_addr), 32'd0);
`else
        checkOutput("t6_req_count", 32'(reqs), 32'd1);
        checkOutput("t6_no_retry", 32'(second_req_at), 32'hFFFF_FFFF);
`endif

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
